alu_rs_multi: RTL
=================

Name: alu_rs_multi

Overview:
- Multi-entry ALU reservation station for the Tomasulo core; successor to the single-entry, one-per-FU station.
- Buffers up to ENTRIES issued ALU ops and snoops CDB_CH result broadcast channels to wake waiting operands.
- Selects the oldest ready entry and executes it: add/sub in one cycle, multiply over MUL_LAT cycles.
- Drives one result channel toward the CDB arbiter with a valid/ready handshake.

Parameters:
- WORD_SIZE, 32, operand/result width
- RB_INDEX, 4, reorder-buffer tag width
- ENTRIES, 4, station depth (>=2)
- CDB_CH, 2, number of snooped broadcast channels (>=1)
- MUL_LAT, 3, multiply latency in cycles (>=1)
- OPCODE_WIDTH, 6, opcode width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous squash (mispredict)
- issue_valid  in  1  issue request
- issue_ready  out  1  a free entry exists
- issue_op  in  OPCODE_WIDTH  opcode
- issue_dest  in  RB_INDEX  destination ROB tag
- issue_rj / issue_rk  in  1 each  operand value valid
- issue_vj / issue_vk  in  WORD_SIZE each  operand values; the immediate arrives pre-placed in vk
- issue_qj / issue_qk  in  RB_INDEX each  producer tags when not ready
- cdb_valid  in  CDB_CH  per-channel broadcast valid
- cdb_tag  in  CDB_CH*RB_INDEX  per-channel tag
- cdb_data  in  CDB_CH*WORD_SIZE  per-channel data
- out_valid  out  1  result valid
- out_ready  in  1  arbiter accepts
- out_tag  out  RB_INDEX  result ROB tag
- out_data  out  WORD_SIZE  result
- occupancy  out  $clog2(ENTRIES+1)  occupied entries

Behaviour:
- Reset (async) or flush (next edge): all entries freed, multiply aborted, out_valid=0, out_tag=0, out_data=0, occupancy=0, issue_ready=1.
- Issue: the entry is written on an edge where issue_valid && issue_ready. issue_ready = (occupancy<ENTRIES) from registered state only; an entry freed in the same cycle is not bypassed.
- Wakeup: any cdb channel with valid and a tag equal to an entry's pending q captures that data and sets the ready bit. The same applies to the incoming issue operand in its issue cycle; the same-cycle broadcast is not lost.
- Duplicate tags across channels: lowest channel index wins.
- Select: the oldest entry (by issue order, age matrix) with both operands ready is selected. It is freed in the same edge it enters execute.
- Selection is allowed only when the exec unit is idle and the output register is empty or being accepted (out_valid && out_ready).
- Exec FSM states:
  - EX_IDLE: on select of ADD/ADDI/SUB/SUBI, the result is registered at the next edge with out_valid=1. On select of MUL/MULI, go to EX_MUL with counter=MUL_LAT-1.
  - EX_MUL: decrement the counter; at 0, load out_data/out_tag, set out_valid, return to EX_IDLE. No select occurs during EX_MUL.
- Output hold: out_valid, out_tag and out_data stay stable until out_ready. Back-to-back ALU ops sustain one result per cycle while out_ready=1.
- Arithmetic: modulo 2^WORD_SIZE; MUL returns the low WORD_SIZE bits of the product.
- Unknown opcode: out_data=0, still broadcast so the ROB does not deadlock.
- Immediate forms are identical to the register forms (the operand already sits in vk).
- Flush and issue in the same cycle: flush wins and the issue is dropped.

Decomposition:
- Shared package (existing parameters include): INST_ADD, INST_SUB, INST_MUL, INST_ADDI, INST_SUBI, INST_MULI, WORD_SIZE, RB_INDEX, OPCODE_WIDTH.
- Sub-module rs_entry: one entry's storage, CDB snoop/capture and ready logic, instantiated ENTRIES times.
- The top level holds the age matrix, select logic, exec FSM and output register.

Test Plan:
- Ready ADD vj=5, vk=7, dest=3 issued at cycle 0 -> select at cycle 1; out_valid=1, out_tag=3, out_data=12 at cycle 2.
- SUB with qj=9 pending; cdb ch1 broadcasts tag 9, data 20 at cycle 4; vk=8 -> result 12 at cycle 6. Broadcast in the issue cycle itself -> same result, no lost wakeup.
- MUL 0xFFFF_FFFF*2 with MUL_LAT=3 -> out_data=0xFFFF_FFFE exactly 3 cycles after select. A ready ADD behind it waits for the mul result.
- Fill 4 entries -> issue_ready=0, occupancy=4. Issuing the oldest-ready frees one entry -> issue_ready=1 on the following cycle. Out-of-order readiness -> the oldest ready entry issues first.
- Hold out_ready=0 for 3 cycles -> out_valid, out_tag and out_data stay stable and no new select occurs. Release -> results stream one per cycle.
- Assert flush mid-MUL with 3 entries occupied -> next cycle occupancy=0, out_valid=0, no result emitted. Assert async reset between edges -> outputs clear immediately.

Source files
------------

// File: rtl/alu_rs_multi_pkg.sv
// Shared definitions for the multi-entry ALU reservation station.
// Holds the default widths, the ALU opcode encodings, the exec FSM state type
// and a small opcode-class helper used by the select/exec path.
package alu_rs_multi_pkg;

  localparam int unsigned WORD_SIZE    = 32;
  localparam int unsigned RB_INDEX     = 4;
  localparam int unsigned OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] INST_ADD  = 6'h01;
  localparam logic [OPCODE_WIDTH-1:0] INST_SUB  = 6'h02;
  localparam logic [OPCODE_WIDTH-1:0] INST_MUL  = 6'h03;
  localparam logic [OPCODE_WIDTH-1:0] INST_ADDI = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] INST_SUBI = 6'h05;
  localparam logic [OPCODE_WIDTH-1:0] INST_MULI = 6'h06;

  typedef enum logic [0:0] {
    ExIdle,
    ExMul
  } ex_state_e;

  function automatic logic is_mul(input logic [OPCODE_WIDTH-1:0] op);
    return (op == INST_MUL) || (op == INST_MULI);
  endfunction

endpackage

// File: rtl/alu_rs_multi_rs_entry.sv
// One reservation-station entry: opcode/tag/operand storage plus CDB snooping.
// Ports:
//   clk, reset (async, active-high), flush (sync squash)
//   i_alloc        write this entry from the issue fields this edge
//   i_free         entry entered execute; release it this edge
//   i_op, i_dest, i_rj/i_rk, i_vj/i_vk, i_qj/i_qk   issue fields
//   i_cdb_valid/tag/data                             flattened broadcast channels
//   o_busy, o_ready (busy and both operands valid), o_op, o_dest, o_vj, o_vk
module alu_rs_multi_rs_entry
  import alu_rs_multi_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned RB_INDEX     = 4,
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned CDB_CH       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         i_alloc,
  input  logic                         i_free,
  input  logic [OPCODE_WIDTH-1:0]      i_op,
  input  logic [RB_INDEX-1:0]          i_dest,
  input  logic                         i_rj,
  input  logic                         i_rk,
  input  logic [WORD_SIZE-1:0]         i_vj,
  input  logic [WORD_SIZE-1:0]         i_vk,
  input  logic [RB_INDEX-1:0]          i_qj,
  input  logic [RB_INDEX-1:0]          i_qk,
  input  logic [CDB_CH-1:0]            i_cdb_valid,
  input  logic [CDB_CH*RB_INDEX-1:0]   i_cdb_tag,
  input  logic [CDB_CH*WORD_SIZE-1:0]  i_cdb_data,
  output logic                         o_busy,
  output logic                         o_ready,
  output logic [OPCODE_WIDTH-1:0]      o_op,
  output logic [RB_INDEX-1:0]          o_dest,
  output logic [WORD_SIZE-1:0]         o_vj,
  output logic [WORD_SIZE-1:0]         o_vk
);

  logic                    r_busy, r_rj, r_rk;
  logic [OPCODE_WIDTH-1:0] r_op;
  logic [RB_INDEX-1:0]     r_dest, r_qj, r_qk;
  logic [WORD_SIZE-1:0]    r_vj, r_vk;

  logic                    w_rj_src, w_rk_src, w_hit_j, w_hit_k;
  logic [RB_INDEX-1:0]     w_qj_src, w_qk_src;
  logic [WORD_SIZE-1:0]    w_vj_src, w_vk_src, w_data_j, w_data_k;
  logic                    w_rj_n, w_rk_n;
  logic [WORD_SIZE-1:0]    w_vj_n, w_vk_n;

  // During the issue cycle the snoop looks at the incoming operand so a broadcast
  // landing in the same cycle is captured rather than lost.
  always_comb begin
    w_rj_src = i_alloc ? i_rj : r_rj;
    w_rk_src = i_alloc ? i_rk : r_rk;
    w_vj_src = i_alloc ? i_vj : r_vj;
    w_vk_src = i_alloc ? i_vk : r_vk;
    w_qj_src = i_alloc ? i_qj : r_qj;
    w_qk_src = i_alloc ? i_qk : r_qk;
    w_hit_j  = 1'b0;
    w_hit_k  = 1'b0;
    w_data_j = '0;
    w_data_k = '0;
    // Walk downward so the lowest matching channel is applied last and wins.
    for (int c = CDB_CH - 1; c >= 0; c--) begin
      if (i_cdb_valid[c] && (i_cdb_tag[c*RB_INDEX +: RB_INDEX] == w_qj_src)) begin
        w_hit_j  = 1'b1;
        w_data_j = i_cdb_data[c*WORD_SIZE +: WORD_SIZE];
      end
      if (i_cdb_valid[c] && (i_cdb_tag[c*RB_INDEX +: RB_INDEX] == w_qk_src)) begin
        w_hit_k  = 1'b1;
        w_data_k = i_cdb_data[c*WORD_SIZE +: WORD_SIZE];
      end
    end
    w_rj_n = w_rj_src | w_hit_j;
    w_rk_n = w_rk_src | w_hit_k;
    w_vj_n = (!w_rj_src && w_hit_j) ? w_data_j : w_vj_src;
    w_vk_n = (!w_rk_src && w_hit_k) ? w_data_k : w_vk_src;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_rj   <= 1'b0;
      r_rk   <= 1'b0;
      r_op   <= '0;
      r_dest <= '0;
      r_qj   <= '0;
      r_qk   <= '0;
      r_vj   <= '0;
      r_vk   <= '0;
    end else if (flush) begin
      r_busy <= 1'b0;
    end else begin
      if (i_alloc) begin
        r_busy <= 1'b1;
        r_op   <= i_op;
        r_dest <= i_dest;
        r_qj   <= i_qj;
        r_qk   <= i_qk;
      end else if (i_free) begin
        r_busy <= 1'b0;
      end
      if (i_alloc || r_busy) begin
        r_rj <= w_rj_n;
        r_rk <= w_rk_n;
        r_vj <= w_vj_n;
        r_vk <= w_vk_n;
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_ready = r_busy & r_rj & r_rk;
  assign o_op    = r_op;
  assign o_dest  = r_dest;
  assign o_vj    = r_vj;
  assign o_vk    = r_vk;

endmodule

// File: rtl/alu_rs_multi.sv
// Multi-entry ALU reservation station: ENTRIES rs_entry slots, an age matrix for
// oldest-ready select, a single-cycle add/sub path, a MUL_LAT-cycle multiply and a
// held valid/ready output register toward the CDB arbiter.
// Ports:
//   clk, reset (async, active-high), flush (sync squash)
//   issue_*      issue handshake and operand fields (immediate pre-placed in vk)
//   cdb_*        CDB_CH flattened broadcast channels (valid, tag, data)
//   out_valid/out_ready/out_tag/out_data   result channel
//   occupancy    number of busy entries
module alu_rs_multi
  import alu_rs_multi_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned RB_INDEX     = 4,
  parameter int unsigned ENTRIES      = 4,
  parameter int unsigned CDB_CH       = 2,
  parameter int unsigned MUL_LAT      = 3,
  parameter int unsigned OPCODE_WIDTH = 6,
  localparam int unsigned OCC_W       = $clog2(ENTRIES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [OPCODE_WIDTH-1:0]      issue_op,
  input  logic [RB_INDEX-1:0]          issue_dest,
  input  logic                         issue_rj,
  input  logic                         issue_rk,
  input  logic [WORD_SIZE-1:0]         issue_vj,
  input  logic [WORD_SIZE-1:0]         issue_vk,
  input  logic [RB_INDEX-1:0]          issue_qj,
  input  logic [RB_INDEX-1:0]          issue_qk,
  input  logic [CDB_CH-1:0]            cdb_valid,
  input  logic [CDB_CH*RB_INDEX-1:0]   cdb_tag,
  input  logic [CDB_CH*WORD_SIZE-1:0]  cdb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RB_INDEX-1:0]          out_tag,
  output logic [WORD_SIZE-1:0]         out_data,
  output logic [OCC_W-1:0]             occupancy
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  logic [ENTRIES-1:0]      w_busy, w_rdy, w_alloc, w_sel;
  logic [OPCODE_WIDTH-1:0] w_e_op   [ENTRIES];
  logic [RB_INDEX-1:0]     w_e_dest [ENTRIES];
  logic [WORD_SIZE-1:0]    w_e_vj   [ENTRIES];
  logic [WORD_SIZE-1:0]    w_e_vk   [ENTRIES];

  // r_older[i][j] set means entry i was issued before entry j.
  logic [ENTRIES-1:0]      r_older  [ENTRIES];

  ex_state_e               r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [RB_INDEX-1:0]     r_mul_tag;
  logic [WORD_SIZE-1:0]    r_mul_a, r_mul_b;
  logic                    r_out_valid;
  logic [RB_INDEX-1:0]     r_out_tag;
  logic [WORD_SIZE-1:0]    r_out_data;

  logic [OCC_W-1:0]        w_occ;
  logic                    w_do_issue, w_found, w_sel_en, w_sel_any, w_oldest;
  logic [OPCODE_WIDTH-1:0] w_sel_op;
  logic [RB_INDEX-1:0]     w_sel_dest;
  logic [WORD_SIZE-1:0]    w_sel_vj, w_sel_vk, w_alu;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    alu_rs_multi_rs_entry #(
      .WORD_SIZE   (WORD_SIZE),
      .RB_INDEX    (RB_INDEX),
      .OPCODE_WIDTH(OPCODE_WIDTH),
      .CDB_CH      (CDB_CH)
    ) u_entry (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .i_alloc    (w_alloc[g]),
      .i_free     (w_sel[g]),
      .i_op       (issue_op),
      .i_dest     (issue_dest),
      .i_rj       (issue_rj),
      .i_rk       (issue_rk),
      .i_vj       (issue_vj),
      .i_vk       (issue_vk),
      .i_qj       (issue_qj),
      .i_qk       (issue_qk),
      .i_cdb_valid(cdb_valid),
      .i_cdb_tag  (cdb_tag),
      .i_cdb_data (cdb_data),
      .o_busy     (w_busy[g]),
      .o_ready    (w_rdy[g]),
      .o_op       (w_e_op[g]),
      .o_dest     (w_e_dest[g]),
      .o_vj       (w_e_vj[g]),
      .o_vk       (w_e_vk[g])
    );
  end

  // Occupancy comes from registered busy bits only, so a slot freed this cycle
  // is not offered to issue until the next one.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_occ = w_occ + OCC_W'(w_busy[i]);
    end
  end

  assign occupancy   = w_occ;
  assign issue_ready = (w_occ < OCC_W'(ENTRIES));
  assign w_do_issue  = issue_valid && issue_ready && !flush;

  always_comb begin
    w_alloc = '0;
    w_found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!w_busy[i] && !w_found) begin
        w_alloc[i] = w_do_issue;
        w_found    = 1'b1;
      end
    end
  end

  assign w_sel_en = (r_state == ExIdle) && (!r_out_valid || out_ready) && !flush;

  // An entry is selected if it is ready and no other ready entry is older.
  always_comb begin
    w_sel    = '0;
    w_oldest = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_oldest = w_rdy[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && w_rdy[j] && r_older[j][i]) w_oldest = 1'b0;
      end
      w_sel[i] = w_sel_en && w_oldest;
    end
  end

  assign w_sel_any = |w_sel;

  always_comb begin
    w_sel_op   = '0;
    w_sel_dest = '0;
    w_sel_vj   = '0;
    w_sel_vk   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_sel[i]) begin
        w_sel_op   = w_e_op[i];
        w_sel_dest = w_e_dest[i];
        w_sel_vj   = w_e_vj[i];
        w_sel_vk   = w_e_vk[i];
      end
    end
  end

  // Unknown opcodes produce zero but are still broadcast so the ROB can retire.
  always_comb begin
    w_alu = '0;
    case (w_sel_op)
      INST_ADD, INST_ADDI: w_alu = w_sel_vj + w_sel_vk;
      INST_SUB, INST_SUBI: w_alu = w_sel_vj - w_sel_vk;
      INST_MUL, INST_MULI: w_alu = w_sel_vj * w_sel_vk;
      default:             w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_older[i] <= '0;
    end else begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (w_alloc[k]) begin
          for (int j = 0; j < ENTRIES; j++) begin
            r_older[k][j] <= 1'b0;
            if (j != k) r_older[j][k] <= 1'b1;
          end
        end
      end
    end
  end

  // Exec FSM and output register. The multiply result appears MUL_LAT cycles after
  // its select cycle; with MUL_LAT == 1 it takes the single-cycle path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ExIdle;
      r_cnt       <= '0;
      r_mul_tag   <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_state     <= ExIdle;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_data  <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      unique case (r_state)
        ExIdle: begin
          if (w_sel_any) begin
            if (is_mul(w_sel_op) && (MUL_LAT > 1)) begin
              r_state   <= ExMul;
              r_cnt     <= CNT_W'(MUL_LAT - 1);
              r_mul_tag <= w_sel_dest;
              r_mul_a   <= w_sel_vj;
              r_mul_b   <= w_sel_vk;
            end else begin
              r_out_valid <= 1'b1;
              r_out_tag   <= w_sel_dest;
              r_out_data  <= w_alu;
            end
          end
        end
        ExMul: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state     <= ExIdle;
            r_out_valid <= 1'b1;
            r_out_tag   <= r_mul_tag;
            r_out_data  <= r_mul_a * r_mul_b;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ExIdle;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_tag   = r_out_tag;
  assign out_data  = r_out_data;

endmodule
